// File: rtl/enchimento_if.sv
// rtl/enchimento_if.sv - fill-stage handshake bundle between sequencer and enchimento
interface enchimento_if #(
  parameter int LARGURA_NIVEL = 4
) ();
  logic                     start;
  logic [LARGURA_NIVEL-1:0] nivel_sensor;
  logic [LARGURA_NIVEL-1:0] nivel_alvo;
  logic                     valvula;
  logic                     pronto;
  logic                     erro;

  modport master (
    output start, nivel_sensor, nivel_alvo,
    input  valvula, pronto, erro
  );

  modport slave (
    input  start, nivel_sensor, nivel_alvo,
    output valvula, pronto, erro
  );
endinterface

// File: rtl/enchimento.sv
// rtl/enchimento.sv - drum water-fill stage with debounce and sticky timeout
// REPOSICAO_NIVEL_EN adds top-up from PRONTO through REPONDO with hysteresis.
module enchimento #(
  parameter int LARGURA_NIVEL        = 4,
  parameter int TEMPO_MAX_ENCHIMENTO = 12,
  parameter int CICLOS_ESTAVEL       = 3
`ifdef REPOSICAO_NIVEL_EN
  , parameter int HISTERESE          = 2
`endif
) (
  input logic         clock,
  input logic         reset_n,
  enchimento_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO,
    ENCHENDO,
    PRONTO,
    ERRO
`ifdef REPOSICAO_NIVEL_EN
    , REPONDO
`endif
  } estado_t;

  localparam logic [7:0] TEMPO_MAX = 8'(TEMPO_MAX_ENCHIMENTO);
  localparam logic [3:0] ESTAVEL   = 4'(CICLOS_ESTAVEL);

  estado_t                  state_q, state_d;
  logic                     valvula_q, valvula_d;
  logic                     pronto_q, pronto_d;
  logic                     erro_q, erro_d;
  logic [LARGURA_NIVEL-1:0] alvo_q, alvo_d;
  logic [7:0]               tempo_q, tempo_d;
  logic [3:0]               estavel_q, estavel_d;

  logic                     cheio;
  logic [7:0]               tempo_inc;
  logic [3:0]               estavel_inc;
`ifdef REPOSICAO_NIVEL_EN
  localparam logic [LARGURA_NIVEL:0] HIST = (LARGURA_NIVEL+1)'(HISTERESE);
  logic                     baixo;
  // One extra bit so sensor + hysteresis never wraps.
  assign baixo = ({1'b0, bus.nivel_sensor} + HIST) < {1'b0, alvo_q};
`endif

  assign cheio       = bus.nivel_sensor >= alvo_q;
  assign tempo_inc   = (tempo_q >= TEMPO_MAX) ? TEMPO_MAX : tempo_q + 8'd1;
  assign estavel_inc = cheio ? estavel_q + 4'd1 : 4'd0;

  always_comb begin
    state_d   = state_q;
    valvula_d = valvula_q;
    pronto_d  = pronto_q;
    erro_d    = erro_q;
    alvo_d    = alvo_q;
    tempo_d   = tempo_q;
    estavel_d = estavel_q;
    if (!bus.start) begin
      state_d   = OCIOSO;
      valvula_d = 1'b0;
      pronto_d  = 1'b0;
      erro_d    = 1'b0;
      alvo_d    = '0;
      tempo_d   = '0;
      estavel_d = '0;
    end else begin
      case (state_q)
        OCIOSO: begin
          state_d   = ENCHENDO;
          alvo_d    = bus.nivel_alvo;
          tempo_d   = '0;
          estavel_d = '0;
          valvula_d = bus.nivel_sensor < bus.nivel_alvo;
          pronto_d  = 1'b0;
          erro_d    = 1'b0;
        end
        ENCHENDO
`ifdef REPOSICAO_NIVEL_EN
        , REPONDO
`endif
        : begin
          tempo_d   = tempo_inc;
          estavel_d = estavel_inc;
          valvula_d = !cheio;
          // Debounce completion beats timeout on the same edge.
          if (estavel_inc >= ESTAVEL) begin
            state_d   = PRONTO;
            pronto_d  = 1'b1;
            valvula_d = 1'b0;
          end else if (tempo_inc >= TEMPO_MAX) begin
            state_d   = ERRO;
            erro_d    = 1'b1;
            pronto_d  = 1'b0;
            valvula_d = 1'b0;
          end
        end
        PRONTO: begin
          pronto_d  = 1'b1;
          valvula_d = 1'b0;
`ifdef REPOSICAO_NIVEL_EN
          // pronto stays high while topping up so the heater is not restarted.
          if (baixo) begin
            state_d   = REPONDO;
            valvula_d = 1'b1;
            tempo_d   = '0;
            estavel_d = '0;
          end
`endif
        end
        ERRO: begin
          erro_d    = 1'b1;
          pronto_d  = 1'b0;
          valvula_d = 1'b0;
        end
        default: state_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= OCIOSO;
      valvula_q <= 1'b0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      alvo_q    <= '0;
      tempo_q   <= '0;
      estavel_q <= '0;
    end else begin
      state_q   <= state_d;
      valvula_q <= valvula_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
      alvo_q    <= alvo_d;
      tempo_q   <= tempo_d;
      estavel_q <= estavel_d;
    end
  end

  assign bus.valvula = valvula_q;
  assign bus.pronto  = pronto_q;
  assign bus.erro    = erro_q;

endmodule

// File: tb/tb_enchimento.sv
// tb/tb_enchimento.sv - directed self-checking bench for enchimento
module tb_enchimento;

`ifdef REPOSICAO_NIVEL_EN
  localparam bit REPOSICAO = 1'b1;
`else
  localparam bit REPOSICAO = 1'b0;
`endif

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  enchimento_if #(.LARGURA_NIVEL(4)) bus ();

  enchimento dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic p, input logic e);
    check({tag, ".valvula"}, 32'(bus.valvula), 32'(v));
    check({tag, ".pronto"},  32'(bus.pronto),  32'(p));
    check({tag, ".erro"},    32'(bus.erro),    32'(e));
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic back_to_idle();
    bus.start = 1'b0;
    step();
  endtask

  int unsigned glitch_nivel [7] = '{8, 8, 8, 7, 8, 8, 8};
  bit          glitch_valv  [7] = '{0, 0, 0, 1, 0, 0, 0};
  bit          glitch_pronto[7] = '{0, 0, 0, 0, 0, 0, 1};

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    clock            = 1'b0;
    reset_n          = 1'b1;
    bus.start        = 1'b0;
    bus.nivel_sensor = '0;
    bus.nivel_alvo   = '0;
    #2 reset_n = 1'b0;
    #1 check_out("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check_out("idle", 1'b0, 1'b0, 1'b0);

    // Test 1: asynchronous reset in the middle of a fill
    bus.start = 1'b1; bus.nivel_alvo = 4'd8; bus.nivel_sensor = 4'd0;
    for (int k = 0; k < 4; k++) step();
    check_out("t1_fill", 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_out("t1_async", 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step(); step();
    check_out("t1_after", 1'b0, 1'b0, 1'b0);

    // Test 2: ramp 0..8, target change mid-fill ignored
    bus.start = 1'b1; bus.nivel_alvo = 4'd8;
    for (int k = 0; k <= 11; k++) begin
      bus.nivel_sensor = (k < 8) ? 4'(k) : 4'd8;
      step();
      if (k == 0) bus.nivel_alvo = 4'd15;
      check($sformatf("t2_valv_e%0d", k), 32'(bus.valvula), 32'(k < 8));
      check($sformatf("t2_pronto_e%0d", k), 32'(bus.pronto), 32'(k >= 10));
    end
    back_to_idle();
    check_out("t2_stop", 1'b0, 1'b0, 1'b0);

    // Test 3: a single low sample restarts the debounce
    bus.start = 1'b1; bus.nivel_alvo = 4'd8;
    for (int k = 0; k < 7; k++) begin
      bus.nivel_sensor = 4'(glitch_nivel[k]);
      step();
      check($sformatf("t3_valv_e%0d", k), 32'(bus.valvula), 32'(glitch_valv[k]));
      check($sformatf("t3_pronto_e%0d", k), 32'(bus.pronto), 32'(glitch_pronto[k]));
    end
    back_to_idle();

    // Test 4: timeout
    bus.start = 1'b1; bus.nivel_alvo = 4'd10; bus.nivel_sensor = 4'd3;
    for (int k = 0; k < 12; k++) step();
    check_out("t4_e11", 1'b1, 1'b0, 1'b0);
    step();
    check_out("t4_e12", 1'b0, 1'b0, 1'b1);
    bus.nivel_sensor = 4'd15;
    step(); step();
    check_out("t4_sticky", 1'b0, 1'b0, 1'b1);
    back_to_idle();
    check_out("t4_stop", 1'b0, 1'b0, 1'b0);

    // Test 5a: debounce completes on the timeout edge
    bus.start = 1'b1; bus.nivel_alvo = 4'd10; bus.nivel_sensor = 4'd3;
    for (int k = 0; k < 10; k++) step();
    bus.nivel_sensor = 4'd10;
    step(); step();
    check_out("t5_e11", 1'b0, 1'b0, 1'b0);
    step();
    check_out("t5_tie", 1'b0, 1'b1, 1'b0);
    back_to_idle();

    // Test 5b: zero target
    bus.start = 1'b1; bus.nivel_alvo = 4'd0; bus.nivel_sensor = 4'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t5z_valv_e%0d", k), 32'(bus.valvula), 32'd0);
      check($sformatf("t5z_pronto_e%0d", k), 32'(bus.pronto), 32'(k == 3));
    end
    back_to_idle();

    // Test 6: level drop while PRONTO
    bus.start = 1'b1; bus.nivel_alvo = 4'd8; bus.nivel_sensor = 4'd8;
    for (int k = 0; k < 4; k++) step();
    check_out("t6_full", 1'b0, 1'b1, 1'b0);
    bus.nivel_sensor = 4'd6;
    step();
    check_out("t6_drop6", 1'b0, 1'b1, 1'b0);
    bus.nivel_sensor = 4'd5;
    step();
    check_out("t6_drop5", REPOSICAO, 1'b1, 1'b0);
    step();
    check_out("t6_hold5", REPOSICAO, 1'b1, 1'b0);
    bus.nivel_sensor = 4'd8;
    for (int k = 0; k < 3; k++) begin
      step();
      check_out($sformatf("t6_refill%0d", k), 1'b0, 1'b1, 1'b0);
    end
    back_to_idle();
    check_out("t6_stop", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
